dmem_responder: RTL and testbench

- Memory-side responder for the processor's 64-bit data port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, commits byte-strobed writes into a local doubleword array, and returns a response over a second valid/ready handshake.
- Replaces the zero-latency data cache when multi-cycle memory timing is exercised.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the data-memory responder.
//   state_e      - responder FSM states (IDLE, BUSY, RESP)
//   DW_*         - doubleword geometry; ADDR_LSB is the byte-offset width
//   strobe_merge - byte-wise merge of new data into an old doubleword
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int unsigned DW_BYTES = 8;
  localparam int unsigned DW_BITS  = 64;
  localparam int unsigned ADDR_LSB = 3;

  // Bytes whose strobe bit is set come from new_data, the rest keep old_data.
  function automatic logic [DW_BITS-1:0] strobe_merge(input logic [DW_BITS-1:0]  old_data,
                                                      input logic [DW_BITS-1:0]  new_data,
                                                      input logic [DW_BYTES-1:0] strb);
    logic [DW_BITS-1:0] res;
    res = old_data;
    for (int i = 0; i < DW_BYTES; i++) begin
      if (strb[i]) res[8*i +: 8] = new_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port array of 2^DEPTH_LOG2 64-bit doublewords.
// Synchronous byte-strobed write, combinational read of the same index.
//   clk_i   - clock
//   we_i    - write enable for this cycle
//   idx_i   - doubleword index (shared by read and write)
//   wdata_i - write data
//   wstrb_i - per-byte write enables
//   rdata_o - current contents at idx_i
module dmem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [DW_BITS-1:0]    wdata_i,
  input  logic [DW_BYTES-1:0]   wstrb_i,
  output logic [DW_BITS-1:0]    rdata_o
);

  logic [DW_BITS-1:0] mem_q [2**DEPTH_LOG2];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= strobe_merge(mem_q[idx_i], wdata_i, wstrb_i);
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the 64-bit data port.
// One request at a time: IDLE accepts, BUSY counts LATENCY wait states and
// commits on its last cycle, RESP holds a registered response until taken.
//   clk, reset               - clock, synchronous active-high reset
//   req_valid / req_ready    - request handshake
//   req_wr, req_addr         - store flag, doubleword address (byte addr [31:3])
//   req_wdata, req_wstrb     - store data and byte enables
//   resp_valid / resp_ready  - response handshake
//   resp_rdata, resp_err     - load data (0 for stores/errors), out-of-range flag
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [28:0]         req_addr,
  input  logic [DW_BITS-1:0]  req_wdata,
  input  logic [DW_BYTES-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DW_BITS-1:0]  resp_rdata,
  output logic                resp_err
);

  localparam int unsigned CntW       = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [32:0] ArrayBytes = 33'(DW_BYTES) << DEPTH_LOG2;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                wr_q;
  logic [28:0]         addr_q;
  logic [DW_BITS-1:0]  wdata_q;
  logic [DW_BYTES-1:0] wstrb_q;
  logic                resp_valid_q;
  logic [DW_BITS-1:0]  rdata_q;
  logic                err_q;

  logic [32:0]        offset;
  logic               in_range;
  logic               commit;
  logic               arr_we;
  logic [DW_BITS-1:0] arr_rdata;

  // 33-bit subtraction: an address below BASE_ADDR sets bit 32 and so
  // compares as out of range instead of wrapping into the array.
  always_comb begin
    offset   = {1'b0, addr_q, {ADDR_LSB{1'b0}}} - {1'b0, BASE_ADDR};
    in_range = offset < ArrayBytes;
    commit   = (state_q == BUSY) && (cnt_q == '0);
    arr_we   = commit && wr_q && in_range && !reset;
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk),
    .we_i   (arr_we),
    .idx_i  (addr_q[DEPTH_LOG2-1:0]),
    .wdata_i(wdata_q),
    .wstrb_i(wstrb_q),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            cnt_q   <= CntW'(LATENCY);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            // Commit cycle: the array write (if any) lands on this same edge.
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= (!wr_q && in_range) ? arr_rdata : '0;
            err_q        <= !in_range;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Three instances (LATENCY 2, 0, 3; 16-word
// arrays at base 0) share stimulus; sel picks which one sees req_valid and
// whose outputs are observed. Unselected instances always have resp_ready=1.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_wr;
  logic [28:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_ready;
  int          sel;

  logic        req_valid_v  [3];
  logic        resp_ready_v [3];
  logic        req_ready_w  [3];
  logic        resp_valid_w [3];
  logic [63:0] resp_rdata_w [3];
  logic        resp_err_w   [3];

  logic        req_ready_s;
  logic        resp_valid_s;
  logic [63:0] resp_rdata_s;
  logic        resp_err_s;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      req_valid_v[k]  = req_valid && (sel == k);
      resp_ready_v[k] = (sel == k) ? resp_ready : 1'b1;
    end
    req_ready_s  = req_ready_w[sel];
    resp_valid_s = resp_valid_w[sel];
    resp_rdata_s = resp_rdata_w[sel];
    resp_err_s   = resp_err_w[sel];
  end

  dmem_responder #(.DEPTH_LOG2(4), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_ready(req_ready_w[0]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid_w[0]), .resp_ready(resp_ready_v[0]),
    .resp_rdata(resp_rdata_w[0]), .resp_err(resp_err_w[0])
  );

  dmem_responder #(.DEPTH_LOG2(4), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut_l0 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_ready(req_ready_w[1]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid_w[1]), .resp_ready(resp_ready_v[1]),
    .resp_rdata(resp_rdata_w[1]), .resp_err(resp_err_w[1])
  );

  dmem_responder #(.DEPTH_LOG2(4), .LATENCY(3), .BASE_ADDR(32'h0)) u_dut_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[2]), .req_ready(req_ready_w[2]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid_w[2]), .resp_ready(resp_ready_v[2]),
    .resp_rdata(resp_rdata_w[2]), .resp_err(resp_err_w[2])
  );

  // One full transaction with resp_ready held high. lat = edges from the accept
  // edge until resp_valid is seen; busy = cycles with req_ready low after accept.
  task automatic xact(input logic wr, input logic [28:0] addr, input logic [63:0] wdata,
                      input logic [7:0] wstrb, output logic [63:0] rdata, output logic err,
                      output int lat, output int busy);
    int n;
    resp_ready = 1'b1;
    req_wr = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; req_valid = 1'b1;
    n = 0;
    while (req_ready_s !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready_s);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0; busy = 0;
    while (resp_valid_s !== 1'b1 && n < 50) begin
      if (req_ready_s === 1'b0) busy++;
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL resp_timeout: resp_valid=%b, required 1", resp_valid_s);
    end
    if (req_ready_s === 1'b0) busy++;
    lat = n; rdata = resp_rdata_s; err = resp_err_s;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; sel = 0;
    req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (req_ready_w[k] !== 1'b0 || resp_valid_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: req_ready=%b resp_valid=%b, required 0 0", k,
                 req_ready_w[k], resp_valid_w[k]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (req_ready_w[k] !== 1'b1 || resp_valid_w[k] !== 1'b0 ||
          resp_rdata_w[k] !== 64'h0 || resp_err_w[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_release[%0d]: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0",
                 k, req_ready_w[k], resp_valid_w[k], resp_rdata_w[k], resp_err_w[k]);
      end
    end
  endtask

  task automatic test_load();
    logic [63:0] rd; logic er; int lat; int busy;
    sel = 0;
    xact(1'b1, 29'h2, 64'h1122_3344_5566_7788, 8'hFF, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h0 || er !== 1'b0) begin
      fails++; $display("FAIL store_resp: rdata=%h err=%b, required 0 0", rd, er);
    end
    xact(1'b0, 29'h2, 64'h0, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h1122_3344_5566_7788 || er !== 1'b0) begin
      fails++;
      $display("FAIL load_data: rdata=%h err=%b, required 1122334455667788 0", rd, er);
    end
    // LATENCY=2: resp_valid seen 3 edges after accept; req_ready low for 4 cycles.
    tests++;
    if (lat != 3 || busy != 4) begin
      fails++; $display("FAIL load_timing: lat=%0d busy=%0d, required 3 4", lat, busy);
    end
  endtask

  task automatic test_strobe();
    logic [63:0] rd; logic er; int lat; int busy;
    sel = 0;
    xact(1'b1, 29'h2, 64'hAABB_CCDD_EEFF_0011, 8'h0F, rd, er, lat, busy);
    xact(1'b0, 29'h2, 64'h0, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h1122_3344_EEFF_0011) begin
      fails++; $display("FAIL strobe_low: rdata=%h, required 11223344eeff0011", rd);
    end
    xact(1'b1, 29'h2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h0 || er !== 1'b0) begin
      fails++; $display("FAIL strobe_zero_resp: rdata=%h err=%b, required 0 0", rd, er);
    end
    xact(1'b1, 29'h2, 64'h9900_0000_0000_0000, 8'h80, rd, er, lat, busy);
    xact(1'b0, 29'h2, 64'h0, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h9922_3344_EEFF_0011) begin
      fails++; $display("FAIL strobe_top: rdata=%h, required 99223344eeff0011", rd);
    end
  endtask

  task automatic test_range();
    logic [63:0] rd; logic er; int lat; int busy;
    sel = 0;
    xact(1'b1, 29'h0, 64'hCAFE_F00D_0000_0001, 8'hFF, rd, er, lat, busy);
    xact(1'b1, 29'hF, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lat, busy);
    // Byte address 0x80 is one past the 16-word array.
    xact(1'b0, 29'h10, 64'h0, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h0 || er !== 1'b1) begin
      fails++; $display("FAIL oor_load: rdata=%h err=%b, required 0 1", rd, er);
    end
    xact(1'b1, 29'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h0 || er !== 1'b1) begin
      fails++; $display("FAIL oor_store: rdata=%h err=%b, required 0 1", rd, er);
    end
    xact(1'b0, 29'h1FFF_FFFF, 64'h0, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h0 || er !== 1'b1) begin
      fails++; $display("FAIL oor_top: rdata=%h err=%b, required 0 1", rd, er);
    end
    xact(1'b0, 29'hF, 64'h0, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h0123_4567_89AB_CDEF || er !== 1'b0) begin
      fails++;
      $display("FAIL oor_last_word: rdata=%h err=%b, required 0123456789abcdef 0", rd, er);
    end
    xact(1'b0, 29'h0, 64'h0, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'hCAFE_F00D_0000_0001) begin
      fails++; $display("FAIL oor_word0: rdata=%h, required cafef00d00000001", rd);
    end
  endtask

  task automatic test_stall();
    logic [63:0] rd; logic er; int lat; int busy; int n;
    sel = 0;
    resp_ready = 1'b0;
    req_wr = 1'b0; req_addr = 29'h2; req_valid = 1'b1;
    n = 0;
    while (req_ready_s !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (resp_valid_s !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      tests++; fails++; $display("FAIL stall_timeout: resp_valid=%b, required 1", resp_valid_s);
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (resp_valid_s !== 1'b1 || resp_rdata_s !== 64'h9922_3344_EEFF_0011 ||
          req_ready_s !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b rdata=%h ready=%b, required 1 99223344eeff0011 0",
                 i, resp_valid_s, resp_rdata_s, req_ready_s);
      end
      // Junk store presented while the response is stalled; must be ignored.
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 29'h2; req_wstrb = 8'hFF;
      req_wdata = 64'(i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready_s !== 1'b1 || resp_valid_s !== 1'b0 || resp_rdata_s !== 64'h0) begin
      fails++;
      $display("FAIL stall_release: ready=%b valid=%b rdata=%h, required 1 0 0",
               req_ready_s, resp_valid_s, resp_rdata_s);
    end
    xact(1'b0, 29'h2, 64'h0, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h9922_3344_EEFF_0011) begin
      fails++; $display("FAIL stall_ignored_req: rdata=%h, required 99223344eeff0011", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er; int lat; int busy;
    int acc[$]; int rsp[$]; logic [63:0] rdv[$];
    logic a;
    sel = 1;
    xact(1'b1, 29'h3, 64'h3333_3333_3333_3333, 8'hFF, rd, er, lat, busy);
    tests++;
    if (lat != 1 || busy != 2) begin
      fails++; $display("FAIL l0_timing: lat=%0d busy=%0d, required 1 2", lat, busy);
    end
    xact(1'b1, 29'h4, 64'h4444_4444_4444_4444, 8'hFF, rd, er, lat, busy);
    req_wr = 1'b0; req_addr = 29'h3; req_valid = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = (req_ready_s === 1'b1);
      @(posedge clk); #1;
      if (a) begin
        acc.push_back(cyc);
        req_addr = 29'h4;
      end
      if (resp_valid_s === 1'b1) begin
        rsp.push_back(cyc);
        rdv.push_back(resp_rdata_s);
      end
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (acc.size() < 2 || rsp.size() < 2) begin
      fails++;
      $display("FAIL b2b_count: accepts=%0d responses=%0d, required >=2 >=2",
               acc.size(), rsp.size());
    end else begin
      // Accepts 3 cycles apart; response visible 1 edge after each accept edge.
      tests++;
      if (acc[1] - acc[0] != 3) begin
        fails++; $display("FAIL b2b_accept_gap: gap=%0d, required 3", acc[1] - acc[0]);
      end
      tests++;
      if (rsp[0] - acc[0] != 1 || rsp[1] - acc[1] != 1) begin
        fails++;
        $display("FAIL b2b_resp_delay: d0=%0d d1=%0d, required 1 1",
                 rsp[0] - acc[0], rsp[1] - acc[1]);
      end
      tests++;
      if (rdv[0] !== 64'h3333_3333_3333_3333 || rdv[1] !== 64'h4444_4444_4444_4444) begin
        fails++;
        $display("FAIL b2b_data: r0=%h r1=%h, required 3333333333333333 4444444444444444",
                 rdv[0], rdv[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er; int lat; int busy; int n;
    sel = 2;
    xact(1'b1, 29'h5, 64'h5555_5555_5555_5555, 8'hFF, rd, er, lat, busy);
    tests++;
    if (lat != 4 || busy != 5) begin
      fails++; $display("FAIL l3_timing: lat=%0d busy=%0d, required 4 5", lat, busy);
    end
    req_wr = 1'b1; req_addr = 29'h5; req_wdata = 64'hDEAD_BEEF_DEAD_BEEF; req_wstrb = 8'hFF;
    req_valid = 1'b1;
    n = 0;
    while (req_ready_s !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++;
      if (resp_valid_s !== 1'b0 || req_ready_s !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_hold[%0d]: valid=%b ready=%b, required 0 0",
                 i, resp_valid_s, req_ready_s);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (req_ready_s !== 1'b1 || resp_valid_s !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_release: ready=%b valid=%b, required 1 0",
               req_ready_s, resp_valid_s);
    end
    xact(1'b0, 29'h5, 64'h0, 8'h00, rd, er, lat, busy);
    tests++;
    if (rd !== 64'h5555_5555_5555_5555) begin
      fails++; $display("FAIL mid_reset_discard: rdata=%h, required 5555555555555555", rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_strobe();
    test_range();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
